// File: rtl/axis_seq_pkg.sv
// Shared definitions for the AXI-Stream sequence framer: state encoding,
// default geometry and the debug probe width helper.
package axis_seq_pkg;

    typedef enum logic {
        S_PASS = 1'b0,
        S_SEQ  = 1'b1
    } state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_SEQ_WIDTH  = 16;
    localparam int DEF_SEQ_INIT   = 1;

    function automatic int ila_width(input int seq_w);
        return seq_w + 3;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Generic valid/data/last output register; a new beat may be loaded whenever
// the register is empty or the downstream side is taking the current beat.
module axis_out_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o,
    output logic             load_ok_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             last_q;

    assign load_ok_o = !valid_q || ready_i;
    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign last_o    = last_q;

    // Output beat register; data/last hold their value while the slot is empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_ok_o) begin
            if (load_i) begin
                valid_q <= 1'b1;
                data_q  <= data_i;
                last_q  <= last_i;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axis_seq_framer.sv
// Passes AXI-Stream frames through and appends a trailer beat holding a
// per-frame sequence number. Debug probes enabled by AXIS_SEQ_FRAMER_ILA_EN.
module axis_seq_framer
    import axis_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SEQ_WIDTH  = DEF_SEQ_WIDTH,
    parameter int SEQ_INIT   = DEF_SEQ_INIT
) (
    input  logic                  m_axis_aclk,
    input  logic                  m_axis_areset,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    input  logic                  seq_resync
`ifdef AXIS_SEQ_FRAMER_ILA_EN
    ,
    output logic [ila_width(SEQ_WIDTH)-1:0] ila_out
`endif
);

    localparam logic [SEQ_WIDTH-1:0] SEQ_INIT_V = SEQ_WIDTH'(SEQ_INIT);
    localparam logic [SEQ_WIDTH-1:0] SEQ_MAX_V  = {SEQ_WIDTH{1'b1}};

    state_e                 state_q, state_d;
    logic [SEQ_WIDTH-1:0]   seq_q, seq_d;
    logic                   load_ok_s;
    logic                   load_s;
    logic [DATA_WIDTH-1:0]  load_data_s;
    logic                   load_last_s;
    logic                   s_ready_s;

    axis_out_reg #(
        .WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk_i     (m_axis_aclk),
        .rst_i     (m_axis_areset),
        .load_i    (load_s),
        .data_i    (load_data_s),
        .last_i    (load_last_s),
        .ready_i   (m_axis_tready),
        .valid_o   (m_axis_tvalid),
        .data_o    (m_axis_tdata),
        .last_o    (m_axis_tlast),
        .load_ok_o (load_ok_s)
    );

    assign s_axis_tready = s_ready_s;

    // State and sequence counter registers.
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            state_q <= S_PASS;
            seq_q   <= SEQ_INIT_V;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
        end
    end

    // Next state, output-register load request and slave ready.
    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        load_s      = 1'b0;
        load_data_s = '0;
        load_last_s = 1'b0;
        s_ready_s   = 1'b0;
        case (state_q)
            S_PASS: begin
                s_ready_s = load_ok_s && !m_axis_areset;
                if (s_axis_tvalid && s_ready_s) begin
                    load_s      = 1'b1;
                    load_data_s = s_axis_tdata;
                    if (s_axis_tlast) begin
                        state_d = S_SEQ;
                    end else begin
                        state_d = S_PASS;
                    end
                end else begin
                    state_d = S_PASS;
                end
            end
            S_SEQ: begin
                if (load_ok_s) begin
                    load_s                       = 1'b1;
                    load_data_s[SEQ_WIDTH-1:0]   = seq_q;
                    load_last_s                  = 1'b1;
                    seq_d   = (seq_q == SEQ_MAX_V) ? SEQ_INIT_V : seq_q + SEQ_WIDTH'(1);
                    state_d = S_PASS;
                end else begin
                    state_d = S_SEQ;
                end
            end
            default: begin
                state_d = S_PASS;
            end
        endcase
        // Resync overrides the trailer increment; the trailer keeps the old value.
        if (seq_resync) begin
            seq_d = SEQ_INIT_V;
        end else begin
            seq_d = seq_d;
        end
    end

`ifdef AXIS_SEQ_FRAMER_ILA_EN
    logic [ila_width(SEQ_WIDTH)-1:0] ila_q;

    // Registered debug probe snapshot.
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            ila_q <= '0;
        end else begin
            ila_q <= {seq_q, m_axis_tvalid & m_axis_tready,
                      m_axis_tvalid & !m_axis_tready, state_q == S_SEQ};
        end
    end

    assign ila_out = ila_q;
`endif

endmodule

// File: tb/tb_axis_seq_framer.sv
// Directed table-driven bench for axis_seq_framer, plus hand-written
// sequences for reset mid-frame and 4-bit counter wrap.
module tb_axis_seq_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        m_tready;
    logic        resync;
    logic        s_tready, m_tvalid, m_tlast;
    logic [31:0] m_tdata;
    logic        s4_tready, m4_tvalid, m4_tlast;
    logic [31:0] m4_tdata;
`ifdef AXIS_SEQ_FRAMER_ILA_EN
    logic [18:0] ila;
    logic [6:0]  ila4;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    axis_seq_framer #(.DATA_WIDTH(32), .SEQ_WIDTH(16), .SEQ_INIT(1)) dut (
        .m_axis_aclk   (clk),
        .m_axis_areset (rst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .seq_resync    (resync)
`ifdef AXIS_SEQ_FRAMER_ILA_EN
        ,
        .ila_out       (ila)
`endif
    );

    axis_seq_framer #(.DATA_WIDTH(32), .SEQ_WIDTH(4), .SEQ_INIT(1)) dut4 (
        .m_axis_aclk   (clk),
        .m_axis_areset (rst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s4_tready),
        .m_axis_tvalid (m4_tvalid),
        .m_axis_tdata  (m4_tdata),
        .m_axis_tlast  (m4_tlast),
        .m_axis_tready (m_tready),
        .seq_resync    (resync)
`ifdef AXIS_SEQ_FRAMER_ILA_EN
        ,
        .ila_out       (ila4)
`endif
    );

    typedef struct {
        logic        tv;
        logic [31:0] td;
        logic        tl;
        logic        mr;
        logic        rs;
        logic        exp_sready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic tv, input logic [31:0] td, input logic tl,
                                input logic mr, input logic rs, input logic er,
                                input logic ev, input logic [31:0] ed, input logic el);
        vec_t v;
        v.tv = tv; v.td = td; v.tl = tl; v.mr = mr; v.rs = rs;
        v.exp_sready = er; v.exp_valid = ev; v.exp_data = ed; v.exp_last = el;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic tv, input logic [31:0] td, input logic tl,
                         input logic mr, input logic rs);
        s_tvalid = tv; s_tdata = td; s_tlast = tl; m_tready = mr; resync = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        s_tvalid = 1'b1;
        #2;
        chk("reset_sready", {31'd0, s_tready}, 32'd0);
        tick();
        chk("reset_valid", {31'd0, m_tvalid}, 32'd0);
        chk("reset_data", m_tdata, 32'd0);
        chk("reset_last", {31'd0, m_tlast}, 32'd0);
        rst = 1'b0;
        s_tvalid = 1'b0;

        // tv, td, tl, mr, rs | sready, valid, data, last
        add(1'b1, 32'hA,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA,  1'b0);
        add(1'b1, 32'hB,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB,  1'b0);
        add(1'b1, 32'hC,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hC,  1'b0);
        add(1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1,  1'b1);
        add(1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0);
        // back-to-back single-beat frames, source holding valid
        add(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0);
        add(1'b1, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2,  1'b1);
        add(1'b1, 32'h20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 1'b0);
        add(1'b1, 32'h30, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3,  1'b1);
        add(1'b1, 32'h30, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h30, 1'b0);
        add(1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4,  1'b1);
        add(1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0);
        // trailer held under 4 cycles of backpressure
        add(1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
        add(1'b1, 32'h50, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5,  1'b1);
        add(1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5,  1'b1);
        add(1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5,  1'b1);
        add(1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5,  1'b1);
        add(1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5,  1'b1);
        add(1'b1, 32'h50, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h50, 1'b0);
        add(1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0);
        // resync coinciding with a trailer load
        add(1'b1, 32'h60, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h60, 1'b0);
        add(1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h6,  1'b1);
        add(1'b1, 32'h70, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h70, 1'b0);
        add(1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1,  1'b1);
        add(1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0);
        // load into an empty register while downstream is not ready
        add(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 1'b0);
        add(1'b1, 32'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
        add(1'b1, 32'h81, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h81, 1'b0);
        add(1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2,  1'b1);
        add(1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0);

        foreach (vq[i]) begin
            drive(vq[i].tv, vq[i].td, vq[i].tl, vq[i].mr, vq[i].rs);
            #2;
            chk($sformatf("v%0d_sready", i), {31'd0, s_tready}, {31'd0, vq[i].exp_sready});
            tick();
            chk($sformatf("v%0d_valid", i), {31'd0, m_tvalid}, {31'd0, vq[i].exp_valid});
            if (vq[i].exp_valid) begin
                chk($sformatf("v%0d_data", i), m_tdata, vq[i].exp_data);
                chk($sformatf("v%0d_last", i), {31'd0, m_tlast}, {31'd0, vq[i].exp_last});
            end
        end

        // reset after beat 2 of a 4-beat frame
        drive(1'b1, 32'h90, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, 32'h91, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, 32'h92, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        #2;
        chk("midrst_sready", {31'd0, s_tready}, 32'd0);
        tick();
        rst = 1'b0;
        chk("midrst_valid", {31'd0, m_tvalid}, 32'd0);
        chk("midrst_data", m_tdata, 32'd0);
        chk("midrst_last", {31'd0, m_tlast}, 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
        chk("midrst_idle_valid", {31'd0, m_tvalid}, 32'd0);
        drive(1'b1, 32'hA0, 1'b1, 1'b1, 1'b0); tick();
        chk("midrst_beat", m_tdata, 32'hA0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
        chk("midrst_trailer", m_tdata, 32'h1);
        chk("midrst_trailer_last", {31'd0, m_tlast}, 32'd1);

        // 16 single-beat frames: 4-bit counter wraps 15 -> 1
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 32'(k + 256), 1'b1, 1'b1, 1'b0); tick();
            chk($sformatf("wrap%0d_beat", k), m4_tdata, 32'(k + 256));
            drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
            chk($sformatf("wrap%0d_trl4", k), m4_tdata, (k < 15) ? 32'(k + 1) : 32'd1);
            chk($sformatf("wrap%0d_last4", k), {31'd0, m4_tlast & m4_tvalid}, 32'd1);
            chk($sformatf("wrap%0d_trl16", k), m_tdata, 32'(k + 1));
        end
        tick();
        chk("final_valid", {31'd0, m_tvalid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
